// File: rtl/notification_pkg.sv
// notification_pkg: shared channel indices and hub FSM state type
package notification_pkg;
  localparam int CH_WHATSAPP = 0;
  localparam int CH_LINKEDIN = 1;
  localparam int CH_GMAIL    = 2;
  localparam int CH_SMS      = 3;
  localparam int CH_YOUTUBE  = 4;
  localparam int CH_FACEBOOK = 5;
  localparam int CH_CALENDAR = 6;
  localparam int CH_CALLS    = 7;
  typedef enum logic {IDLE, OFFER} state_t;
endpackage

// File: rtl/notif_rr_pick.sv
// notif_rr_pick: combinational rotate-priority search, first set req bit at or after ptr
module notif_rr_pick #(
  parameter int N    = 8,
  parameter int CH_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [CH_W-1:0] ptr,
  output logic            any,
  output logic [CH_W-1:0] idx
);
  assign any = |req;
  // walk distances from farthest to nearest so the closest requester at/after ptr wins
  always_comb begin
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) idx = CH_W'((int'(ptr) + k) % N);
  end
endmodule

// File: rtl/notification_hub.sv
// notification_hub: latches app events, offers pending apps round-robin over valid/ready (optional NOTIF_COUNT_EN adds per-channel counters and out_count)
module notification_hub
  import notification_pkg::*;
#(
  parameter int N       = 8,
  parameter int CH_W    = $clog2(N),
  parameter int COUNT_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    a,
  input  logic [N-1:0]    mute,
  input  logic            clear_all,
  input  logic [CH_W-1:0] s,
  output logic            y,
  output logic            out_valid,
  output logic [CH_W-1:0] out_ch,
  input  logic            out_ready
`ifdef NOTIF_COUNT_EN
  ,
  output logic [COUNT_W-1:0] out_count
`endif
);
`ifdef NOTIF_COUNT_EN
  localparam int CW = COUNT_W;
`else
  localparam int CW = 1;
`endif
  if (N < 2 || COUNT_W < 1) begin : g_bad_params
    $error("notification_hub: N must be >= 2 and COUNT_W >= 1");
  end
  logic [N-1:0]    a_q, rise, pending, cand;
  logic [CW-1:0]   cnt_q [N];
  logic [CW-1:0]   cnt_d [N];
  state_t          state_q, state_d;
  logic            out_valid_q, out_valid_d, accept, any;
  logic [CH_W-1:0] out_ch_q, out_ch_d, rr_ptr_q, rr_ptr_d, pick_idx;
`ifdef NOTIF_COUNT_EN
  logic [CW-1:0]   out_count_q, out_count_d;
  assign out_count = out_count_q;
`endif
  assign rise      = a & ~a_q;
  assign cand      = pending & ~mute;
  assign accept    = out_valid_q & out_ready;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign y         = (int'(s) < N) ? pending[s] : 1'b0;
  notif_rr_pick #(.N(N), .CH_W(CH_W)) u_pick (
    .req(cand),
    .ptr(rr_ptr_q),
    .any(any),
    .idx(pick_idx)
  );
  // per-channel counters: a rise on the channel being accepted survives as a fresh event
  always_comb begin
    for (int i = 0; i < N; i++) begin
      pending[i] = cnt_q[i] != '0;
      cnt_d[i]   = cnt_q[i];
      if (accept && out_ch_q == CH_W'(i)) cnt_d[i] = rise[i] ? CW'(1) : '0;
      else if (rise[i] && cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + 1'b1;
      if (clear_all) cnt_d[i] = '0;
    end
  end
  // offer FSM: clear_all beats accept and leaves rr_ptr alone
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
`ifdef NOTIF_COUNT_EN
    out_count_d = out_count_q;
`endif
    if (clear_all) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end else if (state_q == IDLE && any) begin
      state_d     = OFFER;
      out_valid_d = 1'b1;
      out_ch_d    = pick_idx;
`ifdef NOTIF_COUNT_EN
      out_count_d = cnt_q[pick_idx];
`endif
    end else if (state_q == OFFER && accept) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      rr_ptr_d    = (out_ch_q == CH_W'(N - 1)) ? '0 : out_ch_q + 1'b1;
    end
  end
  // state registers, asynchronously cleared so a reset mid-offer drops it at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= '0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
`ifdef NOTIF_COUNT_EN
      out_count_q <= '0;
`endif
    end else begin
      a_q         <= a;
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef NOTIF_COUNT_EN
      out_count_q <= out_count_d;
`endif
    end
  end
endmodule
